// File: rtl/simd_product_accumulator.sv
// simd_product_accumulator: sums BEATS packed product vectors per lane and
// presents the per-lane sums with sticky carry-out flags over valid/ready.
module simd_product_accumulator #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned BEATS  = 4
) (
    input  logic                      CLK,
    input  logic                      nrst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*PROD_W-1:0]   in_prod,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*ACC_W-1:0]    out_acc,
    output logic [LANES-1:0]          out_ovf
);

    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t                       state;
    state_t                       state_nx;
    logic                         in_ready_nx;
    logic                         out_valid_nx;
    logic [CNT_W-1:0]             cnt;
    logic                         accept;
    logic                         last_beat;
    logic [LANES-1:0][ACC_W-1:0]  acc;
    logic [LANES-1:0][ACC_W:0]    sum_c;
    logic [LANES-1:0][ACC_W-1:0]  prod_ext;

    // in_ready is a flop that mirrors the ACCUM state, so accept has no path from out_ready
    assign accept    = in_valid & in_ready;
    assign last_beat = (cnt == CNT_W'(BEATS - 1));
    assign out_acc   = acc;

    // State register with the registered handshake outputs
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state     <= S_ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
        end
    end

    // Next-state: close a set on its last accepted beat, release once the consumer takes it
    always_comb begin
        state_nx = state;
        case (state)
            S_ACCUM: if (accept && last_beat) state_nx = S_HOLD;
            S_HOLD:  if (out_ready)           state_nx = S_ACCUM;
            default: state_nx = S_ACCUM;
        endcase
    end

    // Output decode of the upcoming state, captured by the state register
    always_comb begin
        in_ready_nx  = 1'b0;
        out_valid_nx = 1'b0;
        if (state_nx == S_ACCUM) in_ready_nx  = 1'b1;
        if (state_nx == S_HOLD)  out_valid_nx = 1'b1;
    end

    // Beat counter within the current set
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= last_beat ? '0 : cnt + CNT_W'(1);
        end
    end

    // Per-lane zero-extended product and carry-out-capturing sum
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_ext[i] = ACC_W'(in_prod[i*PROD_W +: PROD_W]);
            sum_c[i]    = {1'b0, acc[i]} + {1'b0, prod_ext[i]};
        end
    end

    // Accumulators and sticky overflow: beat 0 restarts the lane, later beats add and wrap
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            acc     <= '0;
            out_ovf <= '0;
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (cnt == '0) begin
                    acc[i]     <= prod_ext[i];
                    out_ovf[i] <= 1'b0;
                end else begin
                    acc[i]     <= sum_c[i][ACC_W-1:0];
                    out_ovf[i] <= out_ovf[i] | sum_c[i][ACC_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_simd_product_accumulator.sv
// Directed bench: a default-width instance and a 9-bit-accumulator instance share stimulus.
module tb_simd_product_accumulator;

    logic        CLK;
    logic        nrst;
    logic        in_valid;
    logic [31:0] in_prod;
    logic        out_ready;

    logic        in_ready_a, out_valid_a;
    logic [63:0] out_acc_a;
    logic [3:0]  out_ovf_a;
    logic        in_ready_b, out_valid_b;
    logic [35:0] out_acc_b;
    logic [3:0]  out_ovf_b;

    int errors = 0;
    int checks = 0;

    simd_product_accumulator dut_a (
        .CLK(CLK), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_prod(in_prod), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_acc(out_acc_a), .out_ovf(out_ovf_a)
    );

    simd_product_accumulator #(.ACC_W(9)) dut_b (
        .CLK(CLK), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_prod(in_prod), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_acc(out_acc_b), .out_ovf(out_ovf_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] prod;
        bit          gaps;
        logic [63:0] exp_a;
        logic [3:0]  ovf_a;
        logic [35:0] exp_b;
        logic [3:0]  ovf_b;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Four beats of the same vector; optional 1..3 idle cycles between beats
    task automatic send_set(input logic [31:0] p, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            chk("no_early_valid", {63'd0, out_valid_a}, 64'd0);
            chk("in_ready_beat", {63'd0, in_ready_a}, 64'd1);
            in_valid = 1'b1;
            in_prod  = p;
            @(negedge CLK);
            in_valid = 1'b0;
            in_prod  = 32'hDEADBEEF;
            if (gaps && k < 3) repeat ((k % 3) + 1) @(negedge CLK);
        end
    endtask

    task automatic chk_result(input vec_t v, input string tag);
        chk({tag, "_valid_a"}, {63'd0, out_valid_a}, 64'd1);
        chk({tag, "_ready_a"}, {63'd0, in_ready_a}, 64'd0);
        chk({tag, "_acc_a"}, out_acc_a, v.exp_a);
        chk({tag, "_ovf_a"}, {60'd0, out_ovf_a}, {60'd0, v.ovf_a});
        chk({tag, "_valid_b"}, {63'd0, out_valid_b}, 64'd1);
        chk({tag, "_acc_b"}, {28'd0, out_acc_b}, {28'd0, v.exp_b});
        chk({tag, "_ovf_b"}, {60'd0, out_ovf_b}, {60'd0, v.ovf_b});
    endtask

    logic [63:0] held_acc;

    initial begin
        tbl[0] = '{32'h00_36_96_E1, 1'b0, 64'h0000_00D8_0258_0384, 4'h0,
                   {9'h000, 9'h0D8, 9'h058, 9'h184}, 4'b0011};
        tbl[1] = '{32'h00_36_96_E1, 1'b1, 64'h0000_00D8_0258_0384, 4'h0,
                   {9'h000, 9'h0D8, 9'h058, 9'h184}, 4'b0011};
        tbl[2] = '{32'hFF_FF_FF_FF, 1'b0, 64'h03FC_03FC_03FC_03FC, 4'h0,
                   {9'h1FC, 9'h1FC, 9'h1FC, 9'h1FC}, 4'hF};
        tbl[3] = '{32'h01_02_03_04, 1'b1, 64'h0004_0008_000C_0010, 4'h0,
                   {9'h004, 9'h008, 9'h00C, 9'h010}, 4'h0};
        tbl[4] = '{32'hE1_E1_E1_E1, 1'b0, 64'h0384_0384_0384_0384, 4'h0,
                   {9'h184, 9'h184, 9'h184, 9'h184}, 4'hF};
        tbl[5] = '{32'h00_00_00_00, 1'b0, 64'h0, 4'h0, 36'h0, 4'h0};

        nrst      = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b1;

        // Reset held for three cycles, released mid-cycle
        repeat (3) begin
            @(negedge CLK);
            chk("rst_valid", {63'd0, out_valid_a}, 64'd0);
            chk("rst_ready", {63'd0, in_ready_a}, 64'd1);
            chk("rst_acc", out_acc_a, 64'd0);
            chk("rst_ovf", {60'd0, out_ovf_a}, 64'd0);
        end
        nrst = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", {63'd0, in_ready_a}, 64'd1);
        chk("post_rst_valid", {63'd0, out_valid_a}, 64'd0);

        // Table: each set, result one cycle after last accept, valid for exactly one cycle
        for (int r = 0; r < 6; r++) begin
            send_set(tbl[r].prod, tbl[r].gaps);
            chk_result(tbl[r], $sformatf("set%0d", r));
            @(negedge CLK);
            chk("valid_one_cycle", {63'd0, out_valid_a}, 64'd0);
            chk("ready_back", {63'd0, in_ready_a}, 64'd1);
        end

        // Backpressure: result held five cycles with in_valid high, nothing consumed
        out_ready = 1'b0;
        send_set(tbl[0].prod, 1'b0);
        chk_result(tbl[0], "bp");
        held_acc = out_acc_a;
        in_valid = 1'b1;
        in_prod  = 32'h11223344;
        repeat (5) begin
            @(negedge CLK);
            chk("bp_valid", {63'd0, out_valid_a}, 64'd1);
            chk("bp_ready", {63'd0, in_ready_a}, 64'd0);
            chk("bp_stable", out_acc_a, held_acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        chk("bp_release_valid", {63'd0, out_valid_a}, 64'd0);
        chk("bp_release_ready", {63'd0, in_ready_a}, 64'd1);
        send_set(tbl[3].prod, 1'b0);
        chk_result(tbl[3], "after_bp");
        @(negedge CLK);

        // Reset in the middle of a set discards the partial sums
        in_valid = 1'b1;
        in_prod  = 32'hE1E1E1E1;
        repeat (2) @(negedge CLK);
        in_valid = 1'b0;
        nrst = 1'b0;
        #2;
        chk("midrst_valid", {63'd0, out_valid_a}, 64'd0);
        chk("midrst_acc", out_acc_a, 64'd0);
        @(negedge CLK);
        nrst = 1'b1;
        @(negedge CLK);
        send_set(32'h5A5A5A5A, 1'b0);
        chk_result('{32'h5A5A5A5A, 1'b0, 64'h0168_0168_0168_0168, 4'h0,
                     {9'h168, 9'h168, 9'h168, 9'h168}, 4'h0}, "midrst");
        @(negedge CLK);
        chk("midrst_done", {63'd0, out_valid_a}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
